// File: rtl/gl_cmd_pkg.sv
// gl_cmd_pkg: shared definitions for the instruction command sequencer.
//   - Opcode constants understood by the geometry/matrix pipeline.
//   - Header word field positions and the END marker.
//   - Sequencer FSM state enum.
package gl_cmd_pkg;

  // Opcodes
  localparam logic [7:0] OP_VERTEX      = 8'h03;
  localparam logic [7:0] OP_COLOR       = 8'h04;
  localparam logic [7:0] OP_MATRIX_MODE = 8'h10;
  localparam logic [7:0] OP_MULTMATRIX  = 8'h11;

  // Header word layout
  localparam int unsigned HDR_FLAG_BIT = 31;
  localparam int unsigned HDR_IMM_MSB  = 15;
  localparam int unsigned HDR_IMM_LSB  = 8;
  localparam int unsigned HDR_OP_MSB   = 7;
  localparam int unsigned HDR_OP_LSB   = 0;
  localparam logic [31:0] HDR_END      = 32'h0000_0000;

  // Words carried by one payload beat
  localparam int unsigned BEAT_WORDS = 4;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StCmd,
    StArg,
    StDone,
    StErr
  } seq_state_e;

endpackage

// File: rtl/inst_hdr_decode.sv
// inst_hdr_decode: combinational command header decoder.
// Ports:
//   hdr_i      header word
//   opcode_o   header[7:0]
//   imm_o      header[15:8] (immediate or payload length)
//   has_arg_o  header[31] payload flag
//   is_end_o   header is the END marker
//   len_err_o  payload flag set with a length above MaxArgs
module inst_hdr_decode
  import gl_cmd_pkg::*;
#(
  parameter int unsigned MaxArgs = 16
) (
  input  logic [31:0] hdr_i,
  output logic [7:0]  opcode_o,
  output logic [7:0]  imm_o,
  output logic        has_arg_o,
  output logic        is_end_o,
  output logic        len_err_o
);

  assign opcode_o  = hdr_i[HDR_OP_MSB:HDR_OP_LSB];
  assign imm_o     = hdr_i[HDR_IMM_MSB:HDR_IMM_LSB];
  assign has_arg_o = hdr_i[HDR_FLAG_BIT];
  assign is_end_o  = (hdr_i == HDR_END);
  assign len_err_o = has_arg_o && (32'(imm_o) > MaxArgs);

endmodule

// File: rtl/inst_cmd_sequencer.sv
// inst_cmd_sequencer: walks the instruction BRAM from a base address, decodes
// each header and issues commands plus payload beats over valid/ready.
// Ports:
//   BRAM_clk / BRAM_rst      clock, synchronous active-high reset
//   start / base_addr        kick-off pulse and first header address
//   rd_addr1 / rd_data0      async single-word header read
//   rd_addr2 / rd_data1..4   async 4-word payload burst read
//   cmd_*                    command header channel
//   arg_*                    payload beat channel
//   busy / done / err        status
//   perf_cmds / perf_stalls  performance counters
// Optional feature: define INST_SEQ_PERF_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
module inst_cmd_sequencer
  import gl_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned MAX_ARGS = 16
) (
  input  logic         BRAM_clk,
  input  logic         BRAM_rst,
  input  logic         start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [31:0]  rd_addr1,
  input  logic [31:0]  rd_data0,
  output logic [31:0]  rd_addr2,
  input  logic [31:0]  rd_data1,
  input  logic [31:0]  rd_data2,
  input  logic [31:0]  rd_data3,
  input  logic [31:0]  rd_data4,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [7:0]   cmd_opcode,
  output logic [7:0]   cmd_imm,
  output logic         cmd_has_arg,
  output logic         arg_valid,
  input  logic         arg_ready,
  output logic [127:0] arg_data,
  output logic [2:0]   arg_cnt,
  output logic         arg_last,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  perf_cmds,
  output logic [15:0]  perf_stalls
);

  localparam int unsigned RemW = $clog2(MAX_ARGS + 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        imm_q, imm_d;
  logic              has_arg_q, has_arg_d;

  logic [7:0] dec_opcode;
  logic [7:0] dec_imm;
  logic       dec_has_arg;
  logic       dec_is_end;
  logic       dec_len_err;

  logic start_ok;
  logic cmd_hs;
  logic arg_hs;

  inst_hdr_decode #(
    .MaxArgs (MAX_ARGS)
  ) u_hdr_decode (
    .hdr_i     (rd_data0),
    .opcode_o  (dec_opcode),
    .imm_o     (dec_imm),
    .has_arg_o (dec_has_arg),
    .is_end_o  (dec_is_end),
    .len_err_o (dec_len_err)
  );

  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone) ||
                              (state_q == StErr));
  assign cmd_hs   = cmd_valid && cmd_ready;
  assign arg_hs   = arg_valid && arg_ready;

  // Outputs are decoded from registered state only.
  assign rd_addr1    = 32'(pc_q);
  assign rd_addr2    = 32'(pc_q);
  assign cmd_valid   = (state_q == StCmd);
  assign cmd_opcode  = opcode_q;
  assign cmd_imm     = imm_q;
  assign cmd_has_arg = has_arg_q;
  assign arg_valid   = (state_q == StArg);
  assign arg_data    = {rd_data1, rd_data2, rd_data3, rd_data4};
  assign arg_cnt     = (32'(rem_q) >= BEAT_WORDS) ? 3'd4 : 3'(rem_q);
  assign arg_last    = arg_valid && (32'(rem_q) <= BEAT_WORDS);
  assign busy        = (state_q == StHdr) || (state_q == StCmd) || (state_q == StArg);
  assign done        = (state_q == StDone);
  assign err         = (state_q == StErr);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rem_d     = rem_q;
    opcode_d  = opcode_q;
    imm_d     = imm_q;
    has_arg_d = has_arg_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_ok) begin
          pc_d    = base_addr;
          state_d = StHdr;
        end
      end
      StHdr: begin
        opcode_d  = dec_opcode;
        imm_d     = dec_imm;
        has_arg_d = dec_has_arg;
        if (dec_is_end) begin
          state_d = StDone;
        end else if (dec_len_err) begin
          state_d = StErr;
        end else begin
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (cmd_hs) begin
          pc_d = pc_q + ADDR_W'(1);
          // A flagged header with zero length carries no beats.
          if (has_arg_q && (imm_q != 8'd0)) begin
            rem_d   = RemW'(imm_q);
            state_d = StArg;
          end else begin
            state_d = StHdr;
          end
        end
      end
      StArg: begin
        if (arg_hs) begin
          pc_d  = pc_q + ADDR_W'(arg_cnt);
          rem_d = rem_q - RemW'(arg_cnt);
          if (arg_last) begin
            state_d = StHdr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge BRAM_clk) begin
    if (BRAM_rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      rem_q     <= '0;
      opcode_q  <= '0;
      imm_q     <= '0;
      has_arg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rem_q     <= rem_d;
      opcode_q  <= opcode_d;
      imm_q     <= imm_d;
      has_arg_q <= has_arg_d;
    end
  end

`ifdef INST_SEQ_PERF_EN
  logic [15:0] perf_cmds_q, perf_cmds_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;
  logic        stall;

  assign stall = (cmd_valid && !cmd_ready) || (arg_valid && !arg_ready);

  always_comb begin
    perf_cmds_d   = perf_cmds_q;
    perf_stalls_d = perf_stalls_q;
    if (start_ok) begin
      perf_cmds_d   = '0;
      perf_stalls_d = '0;
    end else begin
      if (cmd_hs && (perf_cmds_q != 16'hFFFF)) begin
        perf_cmds_d = perf_cmds_q + 16'd1;
      end
      if (stall && (perf_stalls_q != 16'hFFFF)) begin
        perf_stalls_d = perf_stalls_q + 16'd1;
      end
    end
  end

  always_ff @(posedge BRAM_clk) begin
    if (BRAM_rst) begin
      perf_cmds_q   <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cmds_q   <= perf_cmds_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cmds   = perf_cmds_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cmds   = 16'd0;
  assign perf_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_inst_cmd_sequencer.sv
module tb_inst_cmd_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   base_addr;
  logic [31:0]  rd_addr1, rd_addr2;
  logic [31:0]  rd_data0, rd_data1, rd_data2, rd_data3, rd_data4;
  logic         cmd_valid, cmd_ready;
  logic [7:0]   cmd_opcode, cmd_imm;
  logic         cmd_has_arg;
  logic         arg_valid, arg_ready;
  logic [127:0] arg_data;
  logic [2:0]   arg_cnt;
  logic         arg_last;
  logic         busy, done, err;
  logic [15:0]  perf_cmds, perf_stalls;

  logic [31:0] mem [64];
  logic [5:0]  a1, a2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Asynchronous BRAM model with wrapping burst addresses
  assign a1       = rd_addr1[5:0];
  assign a2       = rd_addr2[5:0];
  assign rd_data0 = mem[a1];
  assign rd_data1 = mem[a2];
  assign rd_data2 = mem[a2 + 6'd1];
  assign rd_data3 = mem[a2 + 6'd2];
  assign rd_data4 = mem[a2 + 6'd3];

  inst_cmd_sequencer #(
    .ADDR_W   (6),
    .MAX_ARGS (16)
  ) dut (
    .BRAM_clk    (clk),
    .BRAM_rst    (rst),
    .start       (start),
    .base_addr   (base_addr),
    .rd_addr1    (rd_addr1),
    .rd_data0    (rd_data0),
    .rd_addr2    (rd_addr2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .rd_data3    (rd_data3),
    .rd_data4    (rd_data4),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_imm     (cmd_imm),
    .cmd_has_arg (cmd_has_arg),
    .arg_valid   (arg_valid),
    .arg_ready   (arg_ready),
    .arg_data    (arg_data),
    .arg_cnt     (arg_cnt),
    .arg_last    (arg_last),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .perf_cmds   (perf_cmds),
    .perf_stalls (perf_stalls)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [5:0] base);
    base_addr = base;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  logic [15:0] exp_cmds1, exp_stalls5;

  initial begin
`ifdef INST_SEQ_PERF_EN
    exp_cmds1   = 16'd1;
    exp_stalls5 = 16'd5;
`else
    exp_cmds1   = 16'd0;
    exp_stalls5 = 16'd0;
`endif
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; start = 1'b0; base_addr = '0; cmd_ready = 1'b0; arg_ready = 1'b0;
    mem[0] = 32'h0000_0110;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_arg_valid", arg_valid, 0);
    chk("rst_status", {busy, done, err, arg_last}, 0);
    chk("rst_fields", {cmd_opcode, cmd_imm, cmd_has_arg, arg_cnt}, 0);
    chk("rst_rd_addr1", rd_addr1, 0);
    chk("rst_perf", {perf_cmds, perf_stalls}, 0);

    // Matrix-mode immediate command then END
    kick(6'd0);
    chk("s1_hdr_busy", {busy, cmd_valid}, 2'b10);
    step();
    chk("s1_cmd_valid", cmd_valid, 1);
    chk("s1_cmd_fields", {cmd_opcode, cmd_imm, cmd_has_arg}, {8'h10, 8'h01, 1'b0});
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("s1_after_hs", {cmd_valid, arg_valid, done}, 0);
    chk("s1_pc", rd_addr1, 1);
    step();
    chk("s1_done", {done, busy}, 2'b10);
    chk("s1_perf_cmds", perf_cmds, exp_cmds1);
    step(); step();
    chk("s1_done_hold", done, 1);

    // Color with 3 args, started from DONE
    mem[4] = 32'h8000_0304; mem[5] = 32'h3F80_0000; mem[6] = 0; mem[7] = 0; mem[8] = 0;
    kick(6'd4);
    chk("s2_hdr_addr", rd_addr1, 4);
    step();
    chk("s2_cmd_fields", {cmd_valid, cmd_opcode, cmd_imm, cmd_has_arg},
        {1'b1, 8'h04, 8'h03, 1'b1});
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("s2_arg_valid", {arg_valid, cmd_valid}, 2'b10);
    chk("s2_arg_cnt_last", {arg_cnt, arg_last}, {3'd3, 1'b1});
    chk("s2_arg_w0", arg_data[127:96], 32'h3F80_0000);
    chk("s2_rd_addr2", rd_addr2, 5);
    arg_ready = 1'b1;
    step();
    arg_ready = 1'b0;
    chk("s2_post_beat", {arg_valid, rd_addr1}, {1'b0, 32'd8});
    step();
    chk("s2_done", done, 1);

    // Multmatrix with 16 args; beat 1 stalled for 5 cycles
    mem[10] = 32'h8000_1011;
    for (int i = 0; i < 16; i++) mem[11 + i] = 32'h100 + i;
    mem[27] = 0;
    kick(6'd10);
    step();
    chk("s3_cmd_fields", {cmd_valid, cmd_opcode, cmd_imm}, {1'b1, 8'h11, 8'h10});
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("s3_cnt_last", {arg_valid, arg_cnt, arg_last}, {1'b1, 3'd4, b == 3});
      chk("s3_w0", arg_data[127:96], 32'h100 + 4 * b);
      chk("s3_w3", arg_data[31:0], 32'h103 + 4 * b);
      chk("s3_rd_addr2", rd_addr2, 11 + 4 * b);
      if (b == 1) begin
        arg_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          chk("s3_stall_data", {arg_valid, arg_cnt, arg_data[127:96]},
              {1'b1, 3'd4, 32'h104});
        end
      end
      arg_ready = 1'b1;
      step();
    end
    arg_ready = 1'b0;
    chk("s3_pc_end", {arg_valid, rd_addr1}, {1'b0, 32'd27});
    step();
    chk("s3_done", done, 1);
    chk("s3_perf", {perf_cmds, perf_stalls}, {exp_cmds1, exp_stalls5});

    // Flagged header with zero length: no beats
    mem[40] = 32'h8000_0004; mem[41] = 0;
    kick(6'd40);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("s4_no_beat", {arg_valid, cmd_valid, rd_addr1}, {2'b00, 32'd41});
    step();
    chk("s4_done", done, 1);

    // Oversized payload -> ERR, then recovery
    mem[30] = 32'h8000_1103;
    kick(6'd30);
    step();
    chk("s5_err", {err, busy, cmd_valid, done}, 4'b1000);
    step(); step();
    chk("s5_err_hold", err, 1);
    kick(6'd0);
    chk("s5_recover_hdr", {err, busy}, 2'b01);
    step();
    chk("s5_recover_cmd", {cmd_valid, cmd_opcode}, {1'b1, 8'h10});
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    chk("s5_recover_done", done, 1);

    // Wrapping burst from base 62
    mem[62] = 32'h8000_0303; mem[63] = 32'hAAAA_0001;
    mem[0]  = 32'hAAAA_0002; mem[1]  = 32'hAAAA_0003; mem[2] = 0;
    kick(6'd62);
    step();
    chk("s6_cmd_fields", {cmd_opcode, cmd_imm, cmd_has_arg}, {8'h03, 8'h03, 1'b1});
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("s6_rd_addr2", rd_addr2, 63);
    chk("s6_wrap_data", arg_data[127:32], {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003});
    chk("s6_cnt", {arg_cnt, arg_last}, {3'd3, 1'b1});
    arg_ready = 1'b1;
    step();
    arg_ready = 1'b0;
    chk("s6_pc_wrap", rd_addr1, 2);
    step();
    chk("s6_done", done, 1);

    // Reset during CMD
    kick(6'd62);
    step();
    chk("s7_in_cmd", cmd_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s7_valids", {cmd_valid, arg_valid}, 0);
    chk("s7_status", {busy, done, err, arg_last}, 0);
    chk("s7_fields", {cmd_opcode, cmd_imm, cmd_has_arg, arg_cnt}, 0);
    chk("s7_addr_perf", {rd_addr1, perf_cmds, perf_stalls}, 0);
    step();
    chk("s7_idle_hold", {cmd_valid, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
